// File: rtl/conv_window_ctrl.sv
// Window sequencer for one convolution layer: walks the output map, launches the CIM
// tiles per window and holds their outputs until conv_func has drained them.
module conv_window_ctrl #(
    parameter int IMG_DIM      = 8,
    parameter int KERNEL_DIM   = 3,
    parameter int OUT_DIM      = IMG_DIM - KERNEL_DIM + 1,
    parameter int IBUF_LATENCY = 1,
    parameter int CNT_W        = $clog2(IMG_DIM),
    parameter int PIX_W        = (OUT_DIM > 1) ? $clog2(OUT_DIM * OUT_DIM) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    output logic             o_ready,
    output logic [CNT_W-1:0] o_row,
    output logic [CNT_W-1:0] o_col,
    output logic [PIX_W-1:0] o_pixel_idx,
    output logic             o_cim_start,
    input  logic             i_cim_ready,
    output logic             o_func_start,
    input  logic             i_func_ready,
    input  logic             i_func_done,
    output logic             o_done
);

    localparam int WAIT_W = (IBUF_LATENCY > 1) ? $clog2(IBUF_LATENCY) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(OUT_DIM - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CIM_GO,
        S_CIM_WAIT,
        S_FUNC_REQ,
        S_FUNC_WAIT,
        S_DONE
    } state_t;

    state_t            state_reg;
    logic [CNT_W-1:0]  row_reg;
    logic [CNT_W-1:0]  col_reg;
    logic [PIX_W-1:0]  pix_reg;
    logic [WAIT_W-1:0] wait_reg;
    logic              cim_first_reg;
    logic              ready_reg;
    logic              cim_start_reg;
    logic              func_start_reg;
    logic              done_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg      <= S_IDLE;
            row_reg        <= '0;
            col_reg        <= '0;
            pix_reg        <= '0;
            wait_reg       <= '0;
            cim_first_reg  <= 1'b0;
            ready_reg      <= 1'b1;
            cim_start_reg  <= 1'b0;
            func_start_reg <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            cim_start_reg <= 1'b0;
            done_reg      <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    wait_reg <= '0;
                    if (i_start) begin
                        state_reg <= S_LOAD;
                        ready_reg <= 1'b0;
                    end
                end
                S_LOAD: begin
                    // Give the im2col path time to settle on the new origin.
                    if (wait_reg == WAIT_W'(IBUF_LATENCY - 1)) begin
                        state_reg     <= S_CIM_GO;
                        cim_start_reg <= 1'b1;
                    end else begin
                        wait_reg <= wait_reg + WAIT_W'(1);
                    end
                end
                S_CIM_GO: begin
                    state_reg     <= S_CIM_WAIT;
                    cim_first_reg <= 1'b1;
                end
                S_CIM_WAIT: begin
                    // The CIM may still show ready in the first cycle after the launch.
                    cim_first_reg <= 1'b0;
                    if (!cim_first_reg && i_cim_ready) begin
                        state_reg      <= S_FUNC_REQ;
                        func_start_reg <= 1'b1;
                    end
                end
                S_FUNC_REQ: begin
                    if (!i_func_ready) begin
                        state_reg      <= S_FUNC_WAIT;
                        func_start_reg <= 1'b0;
                    end
                end
                S_FUNC_WAIT: begin
                    if (i_func_done) begin
                        if (row_reg == LAST && col_reg == LAST) begin
                            state_reg <= S_DONE;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg <= S_LOAD;
                            wait_reg  <= '0;
                            pix_reg   <= pix_reg + PIX_W'(1);
                            if (col_reg == LAST) begin
                                col_reg <= '0;
                                row_reg <= row_reg + CNT_W'(1);
                            end else begin
                                col_reg <= col_reg + CNT_W'(1);
                            end
                        end
                    end
                end
                S_DONE: begin
                    state_reg <= S_IDLE;
                    ready_reg <= 1'b1;
                    row_reg   <= '0;
                    col_reg   <= '0;
                    pix_reg   <= '0;
                end
                default: begin
                    state_reg      <= S_IDLE;
                    ready_reg      <= 1'b1;
                    func_start_reg <= 1'b0;
                end
            endcase
        end
    end

    assign o_ready      = ready_reg;
    assign o_row        = row_reg;
    assign o_col        = col_reg;
    assign o_pixel_idx  = pix_reg;
    assign o_cim_start  = cim_start_reg;
    assign o_func_start = func_start_reg;
    assign o_done       = done_reg;

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Bench for conv_window_ctrl: randomised CIM / conv_func responders checked against
// a window list and handshake-timing rules derived from the layer description.
module tb_conv_window_ctrl;

    localparam int IMG_DIM    = 4;
    localparam int KERNEL_DIM = 3;
    localparam int OUT_DIM    = IMG_DIM - KERNEL_DIM + 1;
    localparam int IBUF       = 1;
    localparam int CNT_W      = $clog2(IMG_DIM);
    localparam int PIX_W      = $clog2(OUT_DIM * OUT_DIM);
    localparam int WINS       = OUT_DIM * OUT_DIM;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             i_start = 1'b0;
    logic             i_cim_ready = 1'b1;
    logic             i_func_ready = 1'b1;
    logic             i_func_done = 1'b0;
    logic             o_ready;
    logic [CNT_W-1:0] o_row;
    logic [CNT_W-1:0] o_col;
    logic [PIX_W-1:0] o_pixel_idx;
    logic             o_cim_start;
    logic             o_func_start;
    logic             o_done;

    int checks = 0;
    int errors = 0;

    logic [CNT_W-1:0] exp_row [WINS];
    logic [CNT_W-1:0] exp_col [WINS];
    logic [PIX_W-1:0] exp_idx [WINS];

    conv_window_ctrl #(
        .IMG_DIM     (IMG_DIM),
        .KERNEL_DIM  (KERNEL_DIM),
        .IBUF_LATENCY(IBUF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_start     (i_start),
        .o_ready     (o_ready),
        .o_row       (o_row),
        .o_col       (o_col),
        .o_pixel_idx (o_pixel_idx),
        .o_cim_start (o_cim_start),
        .i_cim_ready (i_cim_ready),
        .o_func_start(o_func_start),
        .i_func_ready(i_func_ready),
        .i_func_done (i_func_done),
        .o_done      (o_done)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (o_ready !== 1'b1 || o_cim_start !== 1'b0 || o_func_start !== 1'b0 || o_done !== 1'b0) begin
                errors++;
                $display("FAIL reset_ctrl got ready=%b cim=%b func=%b done=%b want 1 0 0 0",
                         o_ready, o_cim_start, o_func_start, o_done);
            end
            checks++;
            if (o_row !== '0 || o_col !== '0 || o_pixel_idx !== '0) begin
                errors++;
                $display("FAIL reset_cnt got row=%0d col=%0d idx=%0d want 0 0 0", o_row, o_col, o_pixel_idx);
            end
            i_start      = 1'($urandom_range(0, 1));
            i_cim_ready  = 1'($urandom_range(0, 1));
            i_func_ready = 1'($urandom_range(0, 1));
            i_func_done  = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        i_start = 1'b0; i_cim_ready = 1'b1; i_func_ready = 1'b1; i_func_done = 1'b0;
        rst = 1'b1;
        $display("reset: done");
    endtask

    // Plays the CIM array and conv_func around one frame and checks every cycle.
    task automatic run_frame(input string name, input int stall_win, input int stall_len,
                             input int bp_win, input int bp_len, input bit spurious, input int abort_win);
        int win = 0, t = 0, s = 0, lat = 0, bp = 1, k = 0, t_fs = -1;
        int cyc = 0, next_cim = -1, done_cyc = -1, cim_cnt = 0, done_cnt = 0;
        bit in_win = 0, fs_seen = 0, abort_pending = 0, finished = 0, exp_fs, exp_done;
        @(negedge clk);
        checks++;
        if (o_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s idle_ready got %b want 1", name, o_ready);
        end
        i_start  = 1'b1;
        next_cim = 1 + IBUF;
        while (!finished && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            i_start = 1'b0;
            i_func_done = 1'b0;
            if (abort_pending) begin
                rst = 1'b1;
                checks++;
                if (o_ready !== 1'b1 || o_row !== '0 || o_col !== '0 || o_pixel_idx !== '0) begin
                    errors++;
                    $display("FAIL %s abort_state got ready=%b row=%0d col=%0d idx=%0d want 1 0 0 0",
                             name, o_ready, o_row, o_col, o_pixel_idx);
                end
                checks++;
                if (o_done !== 1'b0 || o_cim_start !== 1'b0 || o_func_start !== 1'b0) begin
                    errors++;
                    $display("FAIL %s abort_pulses got done=%b cim=%b func=%b want 0 0 0",
                             name, o_done, o_cim_start, o_func_start);
                end
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    checks++;
                    if (o_done !== 1'b0 || o_ready !== 1'b1) begin
                        errors++;
                        $display("FAIL %s abort_quiet got done=%b ready=%b want 0 1", name, o_done, o_ready);
                    end
                end
                finished = 1;
            end else begin
                checks++;
                if ((o_cim_start === 1'b1) !== (cyc == next_cim)) begin
                    errors++;
                    $display("FAIL %s cim_start_timing cycle=%0d got %b want %b", name, cyc, o_cim_start, cyc == next_cim);
                end
                if (o_cim_start === 1'b1 && win < WINS) begin
                    cim_cnt++;
                    next_cim = -1;
                    in_win = 1; fs_seen = 0; t = 0; s = 0; t_fs = -1;
                    lat = (win == stall_win) ? stall_len : (spurious ? int'($urandom_range(2, 4)) : int'($urandom_range(0, 3)));
                    bp  = (win == bp_win) ? bp_len : int'($urandom_range(1, 2));
                    k   = int'($urandom_range(0, 3));
                    $display("%s: window %0d origin (%0d,%0d) idx %0d", name, win, o_row, o_col, o_pixel_idx);
                end
                if (in_win) begin
                    checks++;
                    if (o_row !== exp_row[win] || o_col !== exp_col[win] || o_pixel_idx !== exp_idx[win]) begin
                        errors++;
                        $display("FAIL %s window_origin win=%0d got (%0d,%0d,%0d) want (%0d,%0d,%0d)", name, win,
                                 o_row, o_col, o_pixel_idx, exp_row[win], exp_col[win], exp_idx[win]);
                    end
                end
                if (in_win && fs_seen) s++;
                exp_fs = in_win && (fs_seen ? (s <= bp) : (t == t_fs));
                checks++;
                if (o_func_start !== exp_fs) begin
                    errors++;
                    $display("FAIL %s func_start win=%0d t=%0d got %b want %b", name, win, t, o_func_start, exp_fs);
                end
                if (in_win && !fs_seen && exp_fs) begin
                    fs_seen = 1;
                    s = 0;
                end
                exp_done = (cyc == done_cyc);
                checks++;
                if (o_done !== exp_done) begin
                    errors++;
                    $display("FAIL %s done_pulse cycle=%0d got %b want %b", name, cyc, o_done, exp_done);
                end
                if (o_done === 1'b1) done_cnt++;
                if (done_cyc >= 0 && cyc == done_cyc + 1) begin
                    checks++;
                    if (o_ready !== 1'b1 || o_row !== '0 || o_col !== '0 || o_pixel_idx !== '0) begin
                        errors++;
                        $display("FAIL %s return_idle got ready=%b row=%0d col=%0d idx=%0d want 1 0 0 0",
                                 name, o_ready, o_row, o_col, o_pixel_idx);
                    end
                    finished = 1;
                end
                if (in_win) begin
                    if (t == 0) i_cim_ready = 1'b1;
                    else if (t == 1) i_cim_ready = spurious;
                    else i_cim_ready = (t >= 2 + lat);
                    if (t >= 2 && i_cim_ready && t_fs < 0) t_fs = t + 1;
                    i_func_ready = !(fs_seen && s >= bp);
                    if (spurious && t == 1) begin
                        i_start = 1'b1;
                        i_func_done = 1'b1;
                    end
                    if (fs_seen && s == bp + 1 && win == abort_win) begin
                        rst = 1'b0;
                        abort_pending = 1;
                    end else if (fs_seen && s == bp + 1 + k) begin
                        i_func_done = 1'b1;
                        in_win = 0;
                        win++;
                        if (win == WINS) done_cyc = cyc + 1;
                        else next_cim = cyc + 1 + IBUF;
                    end
                    t++;
                end else begin
                    i_cim_ready = 1'b1;
                    i_func_ready = 1'b1;
                end
            end
        end
        i_start = 1'b0; i_func_done = 1'b0; i_cim_ready = 1'b1; i_func_ready = 1'b1; rst = 1'b1;
        if (!finished) begin
            checks++;
            errors++;
            $display("FAIL %s timeout after %0d cycles, window %0d", name, cyc, win);
        end
        if (abort_win < 0) begin
            checks++;
            if (cim_cnt != WINS) begin
                errors++;
                $display("FAIL %s cim_count got %0d want %0d", name, cim_cnt, WINS);
            end
            checks++;
            if (done_cnt != 1) begin
                errors++;
                $display("FAIL %s done_count got %0d want 1", name, done_cnt);
            end
        end
        $display("%s: frame finished, %0d windows launched", name, cim_cnt);
    endtask

    task automatic test_full_frame();
        run_frame("full_frame", -1, 0, -1, 0, 1'b0, -1);
        run_frame("full_frame_rand", -1, 0, -1, 0, 1'b0, -1);
    endtask

    task automatic test_cim_stall();
        run_frame("cim_stall", 1, 20, -1, 0, 1'b0, -1);
    endtask

    task automatic test_func_backpressure();
        run_frame("func_backpressure", -1, 0, 2, 10, 1'b0, -1);
    endtask

    task automatic test_spurious();
        run_frame("spurious", -1, 0, -1, 0, 1'b1, -1);
    endtask

    task automatic test_reset_mid();
        run_frame("reset_mid", -1, 0, -1, 0, 1'b0, 1);
        run_frame("after_reset", -1, 0, -1, 0, 1'b0, -1);
    endtask

    initial begin
        for (int r = 0; r < OUT_DIM; r++) begin
            for (int c = 0; c < OUT_DIM; c++) begin
                exp_row[r * OUT_DIM + c] = CNT_W'(r);
                exp_col[r * OUT_DIM + c] = CNT_W'(c);
                exp_idx[r * OUT_DIM + c] = PIX_W'(r * OUT_DIM + c);
            end
        end
        test_reset();
        test_full_frame();
        test_cim_stall();
        test_func_backpressure();
        test_spurious();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
